// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access stage: access-size constants and helpers
// (common), plus the pipeline bundles and FSM state encoding (temp_storage).
package common;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'b000;
            SIZE_H:  return 3'b001;
            SIZE_W:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] size_strobe(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

package temp_storage;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] alu_result;
        logic [63:0] reg2_value;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  reg_dest_addr;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] result;
        logic        reg_write;
        logic [4:0]  reg_dest_addr;
        logic        misalign;
    } mem_wb_t;

endpackage

// File: rtl/memory_access_if.sv
// Data-bus request/response interface between the memory-access stage
// (master) and the data memory (slave).
interface memory_access_if #(
    parameter int ADDR_W = 64
);
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic              dreq_write;
    logic [7:0]        dreq_strobe;
    logic [63:0]       dreq_data;
    logic              dresp_data_ok;
    logic [63:0]       dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_data,
        input  dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_data,
        output dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/memory_access_align.sv
// Combinational lane alignment: store strobe/data shifting and load
// extraction with sign or zero extension.
module load_store_align
    import common::*;
(
    input  logic [1:0]  st_size,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_data,
    output logic [7:0]  st_strobe,
    output logic [63:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_raw,
    output logic [63:0] ld_result
);
    logic [63:0] shifted;
    logic        sign_en;

    // NOTE: every output and temporary is assigned on every path through
    // this block, so no latch can be inferred.
    always_comb begin
        st_strobe = size_strobe(st_size) << st_off;
        st_wdata  = st_data << {st_off, 3'b000};
        shifted   = ld_raw >> {ld_off, 3'b000};
        sign_en   = ~ld_funct3[2];
        case (ld_funct3[1:0])
            SIZE_B:  ld_result = {{56{sign_en & shifted[7]}},  shifted[7:0]};
            SIZE_H:  ld_result = {{48{sign_en & shifted[15]}}, shifted[15:0]};
            SIZE_W:  ld_result = {{32{sign_en & shifted[31]}}, shifted[31:0]};
            default: ld_result = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// RV64 memory-access pipeline stage: issues loads/stores on the data bus and
// registers the writeback bundle. Macro MEM_MISALIGN_TRAP_EN enables the
// misaligned-access trap; otherwise addresses are force-aligned.
module memory_access
    import common::*;
    import temp_storage::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  ex_mem_t                ex_mem_state,
    input  logic                   flush,
    output logic                   mem_ready,
    memory_access_if.master        dbus,
    output mem_wb_t                mem_wb_state
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    mem_state_t        state_q, state_d;
    logic              killed_q, killed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [7:0]        strobe_q, strobe_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic [63:0]       result_q, result_d;
    mem_wb_t           mem_wb_q, mem_wb_d;

    logic [2:0]        in_off, in_mask, in_aligned_off;
    logic              in_misalign;
    logic [ADDR_W-1:0] issue_addr;
    logic [7:0]        st_strobe;
    logic [63:0]       st_wdata;
    logic [DATA_W-1:0] load_raw;
    logic [63:0]       ld_result;

    assign in_off         = ex_mem_state.alu_result[2:0];
    assign in_mask        = align_mask(ex_mem_state.funct3[1:0]);
    assign in_misalign    = |(in_off & in_mask);
    assign in_aligned_off = in_off & ~in_mask;
    assign issue_addr     = {ex_mem_state.alu_result[ADDR_W-1:3], in_aligned_off};
    assign load_raw       = dbus.dresp_data;

    load_store_align u_align (
        .st_size   (ex_mem_state.funct3[1:0]),
        .st_off    (in_aligned_off),
        .st_data   (ex_mem_state.reg2_value),
        .st_strobe (st_strobe),
        .st_wdata  (st_wdata),
        .ld_funct3 (funct3_q),
        .ld_off    (addr_q[2:0]),
        .ld_raw    (load_raw),
        .ld_result (ld_result)
    );

    always_comb begin
        state_d     = state_q;
        killed_d    = killed_q;
        addr_d      = addr_q;
        write_d     = write_q;
        strobe_d    = strobe_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        result_d    = result_q;
        mem_wb_d    = '0;
        mem_ready   = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (ex_mem_state.valid && !flush) begin
                    if (!(ex_mem_state.mem_read || ex_mem_state.mem_write)) begin
                        mem_wb_d.valid         = 1'b1;
                        mem_wb_d.result        = ex_mem_state.alu_result;
                        mem_wb_d.reg_write     = ex_mem_state.reg_write;
                        mem_wb_d.reg_dest_addr = ex_mem_state.reg_dest_addr;
                    end else if (TRAP_EN && in_misalign) begin
                        mem_wb_d.valid         = 1'b1;
                        mem_wb_d.result        = ex_mem_state.alu_result;
                        mem_wb_d.reg_dest_addr = ex_mem_state.reg_dest_addr;
                        mem_wb_d.misalign      = 1'b1;
                    end else begin
                        state_d     = WAIT;
                        killed_d    = 1'b0;
                        addr_d      = issue_addr;
                        write_d     = ex_mem_state.mem_write;
                        strobe_d    = ex_mem_state.mem_write ? st_strobe : 8'h00;
                        wdata_d     = ex_mem_state.mem_write ? st_wdata : 64'h0;
                        funct3_d    = ex_mem_state.funct3;
                        rd_d        = ex_mem_state.reg_dest_addr;
                        reg_write_d = ex_mem_state.reg_write & ~ex_mem_state.mem_write;
                        result_d    = ex_mem_state.alu_result;
                    end
                end
            end
            WAIT: begin
                // A flush cannot abort the bus transaction; it only suppresses writeback.
                killed_d = killed_q | flush;
                if (dbus.dresp_data_ok) begin
                    state_d = IDLE;
                    if (!killed_q && !flush) begin
                        mem_wb_d.valid         = 1'b1;
                        mem_wb_d.result        = write_q ? result_q : ld_result;
                        mem_wb_d.reg_write     = reg_write_q;
                        mem_wb_d.reg_dest_addr = rd_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            killed_q    <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            strobe_q    <= 8'h00;
            wdata_q     <= 64'h0;
            funct3_q    <= 3'b000;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            result_q    <= 64'h0;
            mem_wb_q    <= '0;
        end else begin
            state_q     <= state_d;
            killed_q    <= killed_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            strobe_q    <= strobe_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            result_q    <= result_d;
            mem_wb_q    <= mem_wb_d;
        end
    end

    // dreq_valid decodes the state flop directly so an asynchronous reset drops it at once.
    assign dbus.dreq_valid  = (state_q == WAIT);
    assign dbus.dreq_addr   = addr_q;
    assign dbus.dreq_write  = write_q;
    assign dbus.dreq_strobe = strobe_q;
    assign dbus.dreq_data   = wdata_q;
    assign mem_wb_state     = mem_wb_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: pass-through, stores,
// loads, flush, reset during a transaction and misaligned accesses.
module tb_memory_access;
    import temp_storage::*;

    logic    clock;
    logic    reset;
    ex_mem_t ex_mem_state;
    logic    flush;
    logic    mem_ready;
    mem_wb_t mem_wb_state;
    int      passed;
    int      total;

    memory_access_if #(.ADDR_W(64)) bus ();

    memory_access #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_mem_state (ex_mem_state),
        .flush        (flush),
        .mem_ready    (mem_ready),
        .dbus         (bus.master),
        .mem_wb_state (mem_wb_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ex_mem_state      = '0;
        flush             = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 64'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (mem_ready !== 1'b1) $display("FAIL reset_mem_ready: got %b want 1", mem_ready);
        else passed++;
        total++;
        if (bus.dreq_valid !== 1'b0) $display("FAIL reset_dreq_valid: got %b want 0", bus.dreq_valid);
        else passed++;
        total++;
        if (mem_wb_state !== '0) $display("FAIL reset_mem_wb: got %h want 0", mem_wb_state);
        else passed++;
        total++;
        if (bus.dreq_strobe !== 8'h00 || bus.dreq_addr !== 64'h0 || bus.dreq_data !== 64'h0 || bus.dreq_write !== 1'b0)
            $display("FAIL reset_dreq_fields: strobe %h addr %h data %h write %b want all 0",
                     bus.dreq_strobe, bus.dreq_addr, bus.dreq_data, bus.dreq_write);
        else passed++;
        #3 reset = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        ex_mem_state               = '0;
        ex_mem_state.valid         = 1'b1;
        ex_mem_state.alu_result    = 64'h1234;
        ex_mem_state.reg_write     = 1'b1;
        ex_mem_state.reg_dest_addr = 5'd5;
        tick();
        ex_mem_state = '0;
        total++;
        if (mem_wb_state.valid !== 1'b1 || mem_wb_state.result !== 64'h1234)
            $display("FAIL add_result: valid %b result %h want 1 / 1234", mem_wb_state.valid, mem_wb_state.result);
        else passed++;
        total++;
        if (mem_wb_state.reg_dest_addr !== 5'd5 || mem_wb_state.reg_write !== 1'b1)
            $display("FAIL add_rd: rd %0d we %b want 5 / 1", mem_wb_state.reg_dest_addr, mem_wb_state.reg_write);
        else passed++;
        total++;
        if (bus.dreq_valid !== 1'b0 || mem_ready !== 1'b1)
            $display("FAIL add_no_request: dreq_valid %b mem_ready %b want 0 / 1", bus.dreq_valid, mem_ready);
        else passed++;
        tick();
        total++;
        if (mem_wb_state.valid !== 1'b0) $display("FAIL add_bubble: valid %b want 0", mem_wb_state.valid);
        else passed++;
    endtask

    task automatic test_store_byte();
        ex_mem_state               = '0;
        ex_mem_state.valid         = 1'b1;
        ex_mem_state.alu_result    = 64'h1003;
        ex_mem_state.reg2_value    = 64'hAB;
        ex_mem_state.funct3        = 3'b000;
        ex_mem_state.mem_write     = 1'b1;
        ex_mem_state.reg_dest_addr = 5'd4;
        tick();
        ex_mem_state = '0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (bus.dreq_valid !== 1'b1 || mem_ready !== 1'b0 || mem_wb_state.valid !== 1'b0)
                $display("FAIL sb_wait_%0d: dreq_valid %b mem_ready %b wb_valid %b want 1/0/0",
                         c, bus.dreq_valid, mem_ready, mem_wb_state.valid);
            else passed++;
            total++;
            if (bus.dreq_strobe !== 8'h08 || bus.dreq_data !== 64'hAB00_0000 ||
                bus.dreq_addr !== 64'h1003 || bus.dreq_write !== 1'b1)
                $display("FAIL sb_fields_%0d: strobe %h data %h addr %h write %b want 08/ab000000/1003/1",
                         c, bus.dreq_strobe, bus.dreq_data, bus.dreq_addr, bus.dreq_write);
            else passed++;
            if (c < 2) tick();
        end
        bus.dresp_data_ok = 1'b1;
        tick();
        bus.dresp_data_ok = 1'b0;
        total++;
        if (mem_wb_state.valid !== 1'b1 || mem_wb_state.reg_write !== 1'b0 || mem_wb_state.result !== 64'h1003)
            $display("FAIL sb_done: valid %b we %b result %h want 1/0/1003",
                     mem_wb_state.valid, mem_wb_state.reg_write, mem_wb_state.result);
        else passed++;
        total++;
        if (bus.dreq_valid !== 1'b0 || mem_ready !== 1'b1)
            $display("FAIL sb_release: dreq_valid %b mem_ready %b want 0/1", bus.dreq_valid, mem_ready);
        else passed++;
    endtask

    task automatic test_store_half();
        ex_mem_state            = '0;
        ex_mem_state.valid      = 1'b1;
        ex_mem_state.alu_result = 64'h0006;
        ex_mem_state.reg2_value = 64'hFFFF_8001;
        ex_mem_state.funct3     = 3'b001;
        ex_mem_state.mem_write  = 1'b1;
        tick();
        ex_mem_state = '0;
        total++;
        if (bus.dreq_strobe !== 8'hC0 || bus.dreq_data[63:48] !== 16'h8001)
            $display("FAIL sh_lanes: strobe %h data %h want c0 / 8001xxxxxxxxxxxx", bus.dreq_strobe, bus.dreq_data);
        else passed++;
        bus.dresp_data_ok = 1'b1;
        tick();
        bus.dresp_data_ok = 1'b0;
        total++;
        if (mem_wb_state.valid !== 1'b1 || mem_wb_state.reg_write !== 1'b0)
            $display("FAIL sh_done: valid %b we %b want 1/0", mem_wb_state.valid, mem_wb_state.reg_write);
        else passed++;
    endtask

    task automatic test_load_byte();
        ex_mem_state               = '0;
        ex_mem_state.valid         = 1'b1;
        ex_mem_state.alu_result    = 64'h2006;
        ex_mem_state.funct3        = 3'b000;
        ex_mem_state.mem_read      = 1'b1;
        ex_mem_state.reg_write     = 1'b1;
        ex_mem_state.reg_dest_addr = 5'd7;
        tick();
        ex_mem_state = '0;
        total++;
        if (bus.dreq_valid !== 1'b1 || bus.dreq_write !== 1'b0 || bus.dreq_addr !== 64'h2006 || bus.dreq_strobe !== 8'h00)
            $display("FAIL lb_request: valid %b write %b addr %h strobe %h want 1/0/2006/00",
                     bus.dreq_valid, bus.dreq_write, bus.dreq_addr, bus.dreq_strobe);
        else passed++;
        bus.dresp_data    = 64'h0080_0000_0000_0000;
        bus.dresp_data_ok = 1'b1;
        tick();
        bus.dresp_data_ok = 1'b0;
        total++;
        if (mem_wb_state.valid !== 1'b1 || mem_wb_state.result !== 64'hFFFF_FFFF_FFFF_FF80)
            $display("FAIL lb_result: valid %b result %h want 1 / ffffffffffffff80", mem_wb_state.valid, mem_wb_state.result);
        else passed++;
        total++;
        if (mem_wb_state.reg_write !== 1'b1 || mem_wb_state.reg_dest_addr !== 5'd7)
            $display("FAIL lb_rd: we %b rd %0d want 1 / 7", mem_wb_state.reg_write, mem_wb_state.reg_dest_addr);
        else passed++;
        // Back-to-back: LBU accepted in the single IDLE cycle after completion.
        ex_mem_state               = '0;
        ex_mem_state.valid         = 1'b1;
        ex_mem_state.alu_result    = 64'h2006;
        ex_mem_state.funct3        = 3'b100;
        ex_mem_state.mem_read      = 1'b1;
        ex_mem_state.reg_write     = 1'b1;
        ex_mem_state.reg_dest_addr = 5'd8;
        tick();
        ex_mem_state = '0;
        total++;
        if (bus.dreq_valid !== 1'b1 || mem_wb_state.valid !== 1'b0)
            $display("FAIL lbu_back_to_back: dreq_valid %b wb_valid %b want 1/0", bus.dreq_valid, mem_wb_state.valid);
        else passed++;
        bus.dresp_data_ok = 1'b1;
        tick();
        bus.dresp_data_ok = 1'b0;
        total++;
        if (mem_wb_state.valid !== 1'b1 || mem_wb_state.result !== 64'h80 || mem_wb_state.reg_dest_addr !== 5'd8)
            $display("FAIL lbu_result: valid %b result %h rd %0d want 1 / 80 / 8",
                     mem_wb_state.valid, mem_wb_state.result, mem_wb_state.reg_dest_addr);
        else passed++;
    endtask

    task automatic test_flush_in_wait();
        ex_mem_state               = '0;
        ex_mem_state.valid         = 1'b1;
        ex_mem_state.alu_result    = 64'h3000;
        ex_mem_state.funct3        = 3'b010;
        ex_mem_state.mem_read      = 1'b1;
        ex_mem_state.reg_write     = 1'b1;
        ex_mem_state.reg_dest_addr = 5'd3;
        tick();
        ex_mem_state = '0;
        flush        = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (bus.dreq_valid !== 1'b1 || mem_ready !== 1'b0)
            $display("FAIL lw_flush_not_aborted: dreq_valid %b mem_ready %b want 1/0", bus.dreq_valid, mem_ready);
        else passed++;
        tick();
        bus.dresp_data    = 64'h1111_2222_3333_4444;
        bus.dresp_data_ok = 1'b1;
        tick();
        bus.dresp_data_ok = 1'b0;
        total++;
        if (mem_wb_state.valid !== 1'b0) $display("FAIL lw_flush_killed: wb_valid %b want 0", mem_wb_state.valid);
        else passed++;
        total++;
        if (mem_ready !== 1'b1 || bus.dreq_valid !== 1'b0)
            $display("FAIL lw_flush_release: mem_ready %b dreq_valid %b want 1/0", mem_ready, bus.dreq_valid);
        else passed++;
    endtask

    task automatic test_reset_in_wait();
        ex_mem_state            = '0;
        ex_mem_state.valid      = 1'b1;
        ex_mem_state.alu_result = 64'h4000;
        ex_mem_state.funct3     = 3'b011;
        ex_mem_state.mem_read   = 1'b1;
        ex_mem_state.reg_write  = 1'b1;
        tick();
        ex_mem_state = '0;
        total++;
        if (bus.dreq_valid !== 1'b1) $display("FAIL ld_request: dreq_valid %b want 1", bus.dreq_valid);
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.dreq_valid !== 1'b0 || mem_ready !== 1'b1)
            $display("FAIL ld_async_reset: dreq_valid %b mem_ready %b want 0/1", bus.dreq_valid, mem_ready);
        else passed++;
        #2 reset = 1'b0;
        bus.dresp_data    = 64'hDEAD_BEEF_0000_0001;
        bus.dresp_data_ok = 1'b1;
        tick();
        bus.dresp_data_ok = 1'b0;
        total++;
        if (mem_wb_state.valid !== 1'b0 || bus.dreq_valid !== 1'b0)
            $display("FAIL ld_stale_response: wb_valid %b dreq_valid %b want 0/0", mem_wb_state.valid, bus.dreq_valid);
        else passed++;
    endtask

    task automatic test_misalign();
        ex_mem_state               = '0;
        ex_mem_state.valid         = 1'b1;
        ex_mem_state.alu_result    = 64'h2002;
        ex_mem_state.funct3        = 3'b010;
        ex_mem_state.mem_read      = 1'b1;
        ex_mem_state.reg_write     = 1'b1;
        ex_mem_state.reg_dest_addr = 5'd9;
        tick();
        ex_mem_state = '0;
`ifdef MEM_MISALIGN_TRAP_EN
        total++;
        if (bus.dreq_valid !== 1'b0) $display("FAIL lw_misalign_no_req: dreq_valid %b want 0", bus.dreq_valid);
        else passed++;
        total++;
        if (mem_wb_state.valid !== 1'b1 || mem_wb_state.misalign !== 1'b1 ||
            mem_wb_state.result !== 64'h2002 || mem_wb_state.reg_write !== 1'b0)
            $display("FAIL lw_misalign_wb: valid %b misalign %b result %h we %b want 1/1/2002/0",
                     mem_wb_state.valid, mem_wb_state.misalign, mem_wb_state.result, mem_wb_state.reg_write);
        else passed++;
`else
        total++;
        if (bus.dreq_valid !== 1'b1 || bus.dreq_addr !== 64'h2000)
            $display("FAIL lw_force_align: dreq_valid %b addr %h want 1 / 2000", bus.dreq_valid, bus.dreq_addr);
        else passed++;
        bus.dresp_data    = 64'h1122_3344_5566_7788;
        bus.dresp_data_ok = 1'b1;
        tick();
        bus.dresp_data_ok = 1'b0;
        total++;
        if (mem_wb_state.valid !== 1'b1 || mem_wb_state.misalign !== 1'b0 || mem_wb_state.result !== 64'h5566_7788)
            $display("FAIL lw_aligned_result: valid %b misalign %b result %h want 1/0/55667788",
                     mem_wb_state.valid, mem_wb_state.misalign, mem_wb_state.result);
        else passed++;
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_passthrough();
        test_store_byte();
        test_store_half();
        test_load_byte();
        test_flush_in_wait();
        test_reset_in_wait();
        test_misalign();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
